level_countdown_timer: RTL

Per-level countdown timer that answers the game controller's timer handshake. On the controller's `start_timer` pulse it loads a level-dependent duration, counts down once per second in BCD, and returns a single-cycle `timerend` pulse when the count reaches zero. It sits beside the game controller. Its BCD digits feed the seven-segment display, and its `warning` output feeds the HUD/audio.

---
 rtl/level_countdown_timer_if.sv | 23 ++
 rtl/level_countdown_timer.sv | 117 +++++++++++
 2 files changed

// File: rtl/level_countdown_timer_if.sv
// Timer handshake between the game controller and the level countdown timer.
// The controller side is the master; the timer side is the slave.
interface level_countdown_timer_if;
  logic       start_timer;
  logic [2:0] level;
  logic       stop_timer;
  logic       pause;
  logic       timerend;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       warning;

  modport master (
    output start_timer, level, stop_timer, pause,
    input  timerend, sec_tens, sec_ones, running, warning
  );

  modport slave (
    input  start_timer, level, stop_timer, pause,
    output timerend, sec_tens, sec_ones, running, warning
  );
endinterface

// File: rtl/level_countdown_timer.sv
// Per-level BCD countdown timer: loads a level-dependent duration on start_timer,
// counts down once per second and pulses timerend when the count reaches 00.
module level_countdown_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BASE_SECONDS  = 60,
  parameter int STEP_SECONDS  = 10,
  parameter int WARN_SECONDS  = 10
) (
  input logic                 clk,
  input logic                 resetN,
  level_countdown_timer_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    tens, tens_nxt;
  logic [3:0]    ones, ones_nxt;
  logic          timerend_q, timerend_nxt;

  logic [2:0]    lvl_eff;
  int            dur_int;
  logic [3:0]    load_tens, load_ones;
  logic          load_zero;
  logic          active, count_en, tick;

  // Duration is worked out in binary, then split into BCD digits for loading.
  always_comb begin
    if (bus.level == 3'd0)     lvl_eff = 3'd1;
    else if (bus.level > 3'd5) lvl_eff = 3'd5;
    else                       lvl_eff = bus.level;
    dur_int = BASE_SECONDS - (int'(lvl_eff) - 1) * STEP_SECONDS;
    if (dur_int < 0)  dur_int = 0;
    if (dur_int > 99) dur_int = 99;
    load_tens = 4'(dur_int / 10);
    load_ones = 4'(dur_int % 10);
    load_zero = (dur_int == 0);
  end

  // Counting is frozen only while pause is high, so the PAUSE->RUN edge counts.
  assign active   = (state == RUN) || (state == PAUSE);
  assign count_en = active && !bus.pause;
  assign tick     = count_en && (presc == PRESC_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt    = state;
    presc_nxt    = presc;
    tens_nxt     = tens;
    ones_nxt     = ones;
    timerend_nxt = 1'b0;

    if (bus.start_timer) begin
      presc_nxt = '0;
      tens_nxt  = load_tens;
      ones_nxt  = load_ones;
      if (load_zero) begin
        state_nxt    = EXPIRED;
        timerend_nxt = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (bus.stop_timer && active) begin
      state_nxt = IDLE;
      presc_nxt = '0;
    end else if (state == RUN && bus.pause) begin
      state_nxt = PAUSE;
    end else if (count_en) begin
      state_nxt = RUN;
      presc_nxt = tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (tens == 4'd0 && ones == 4'd1) begin
          ones_nxt     = 4'd0;
          timerend_nxt = 1'b1;
          state_nxt    = EXPIRED;
        end else if (ones != 4'd0) begin
          ones_nxt = ones - 4'd1;
        end else if (tens != 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = tens - 4'd1;
        end
      end
    end
  end

  // NOTE: the reset branch is asynchronous and active-low, so it sits in the sensitivity list.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      presc      <= '0;
      tens       <= 4'd0;
      ones       <= 4'd0;
      timerend_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      state      <= state_nxt;
      presc      <= presc_nxt;
      tens       <= tens_nxt;
      ones       <= ones_nxt;
      timerend_q <= timerend_nxt;
    end
  end

  int rem_int;
  assign rem_int = int'(tens) * 10 + int'(ones);

  assign bus.timerend = timerend_q;
  assign bus.sec_tens = tens;
  assign bus.sec_ones = ones;
  assign bus.running  = active;
  assign bus.warning  = active && (rem_int != 0) && (rem_int <= WARN_SECONDS);

endmodule
